fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
- Owns the IF-stage program counter and produces the sequential fetch PC consumed by the next-PC selection logic.
- Arbitrates redirect requests from ID (jal/jalr) and EX (taken branch) and flushes the wrong-path IF/ID and ID/EX registers.
- Latches a redirect that arrives while fetch is held, and applies it once fetch resumes.
- Sits between the hazard unit, the instruction-memory port and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, fetch address on a misaligned target; used only with PC_MISALIGN_TRAP_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_IF  in  1  hazard-unit stall; holds the PC.
- jal_ID  in  1  jal decoded in ID.
- jalr_ID  in  1  jalr decoded in ID.
- target_ID  in  32  jal/jalr target computed in ID.
- B_JUMP_EX  in  1  branch resolved taken in EX.
- target_EX  in  32  branch target from EX.
- fetch_ready  in  1  instruction memory accepts the current fetch address.
- fetch_valid  out  1  pc_out_IF is a valid fetch request.
- pc_out_IF  out  32  current fetch PC.
- pc_plus4_IF  out  32  pc_out_IF + 4, for the link value.
- flush_IF_ID  out  1  invalidate the IF/ID register.
- flush_ID_EX  out  1  invalidate the ID/EX register.
- redirect_pending  out  1  a latched redirect is waiting to be applied.
- misalign_trap  out  1  one-cycle pulse; only with PC_MISALIGN_TRAP_EN.
- bad_target  out  32  offending target; only with PC_MISALIGN_TRAP_EN.

Behaviour:
- Reset (rst=1 at a clk edge):
  - pc_out_IF=RESET_PC, pending register cleared, state=BOOT.
  - fetch_valid=0, flush_IF_ID=0, flush_ID_EX=0, redirect_pending=0, misalign_trap=0, bad_target=0.
  - Reset overrides every other input in the same cycle, including mid-pending.
- hold = stall_IF | (fetch_valid & ~fetch_ready).
- Redirect priority:
  - EX beats ID because the EX instruction is older. If B_JUMP_EX=1, the ID jump is on the wrong path and is ignored.
  - EX request: tgt=target_EX; flush_IF_ID=1 and flush_ID_EX=1 in the same cycle (combinational).
  - ID request only (jal_ID|jalr_ID, no EX request): tgt=target_ID; flush_IF_ID=1, flush_ID_EX=0.
  - jal_ID and jalr_ID both high is treated as a single ID request.
  - Flush outputs follow the request inputs regardless of hold.
- Target alignment: bit 0 is always forced to 0. Bit 1 handling is described under Optional Feature.
- FSM states:
  - BOOT: fetch_valid=0 for exactly one cycle, PC unchanged, next state RUN. Redirect inputs in BOOT are ignored.
  - RUN, no request, ~hold: pc <= pc+4. The add is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - RUN, no request, hold: pc unchanged.
  - RUN, request, ~hold: pc <= tgt; stay in RUN.
  - RUN, request, hold: pend <= tgt; go to PEND.
  - PEND, new EX request: overwrites pend.
  - PEND, new ID request: overwrites pend only if the pend entry came from ID. An EX pending entry is never displaced by ID.
  - PEND, ~hold: pc <= pend; go to RUN.
  - PEND, ~hold and a new request in the same cycle: the new request wins, pc <= new tgt.
  - redirect_pending = (state==PEND).
- Latency: a redirect takes effect on pc_out_IF one cycle after the request if not held; otherwise one cycle after hold deasserts.
- fetch_valid=1 in RUN and PEND.
- pc_plus4_IF is always combinational from pc_out_IF.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A selected target with bit 1 set is not applied; the PC is loaded with TRAP_VEC instead.
  - misalign_trap pulses one cycle, coincident with the PC load.
  - bad_target captures the raw target and holds it until the next trap or reset.
  - Flush behaviour is unchanged.
- Undefined: bits [1:0] of the target are forced to 00. misalign_trap and bad_target are absent (ports removed).

Decomposition:
- Shared package (fetch_pkg):
  - state enum {BOOT, RUN, PEND}.
  - ILEN=32'd4.
  - Default RESET_PC and TRAP_VEC constants.
  - Redirect-source encoding {SRC_NONE, SRC_ID, SRC_EX}.
- One sub-module, redirect_arb: purely combinational. Produces source, tgt and the flush pair from the jal_ID, jalr_ID and B_JUMP_EX requests and their targets.
- The PC register, pending register and FSM stay in fetch_pc_ctrl.

Test Plan:
- Reset, no requests, fetch_ready=1: fetch_valid=0 for one cycle, then pc_out_IF=0, 4, 8, 12 on successive cycles.
- Sequential fetch reaching 32'hFFFF_FFFC: next pc_out_IF=32'h0000_0000.
- jal_ID=1, target_ID=32'h40, with B_JUMP_EX=1, target_EX=32'h80 in the same cycle: flush_IF_ID=1 and flush_ID_EX=1 that cycle; next pc_out_IF=32'h80.
- stall_IF=1 for 3 cycles; jalr_ID with target 32'h201 in cycle 1; B_JUMP_EX with 32'h300 in cycle 2: redirect_pending=1 from cycle 2; first cycle after the stall pc_out_IF=32'h300; redirect_pending=0.
- fetch_ready=0 with pc=32'h10 for 2 cycles: pc holds 32'h10, then advances to 32'h14.
- PC_MISALIGN_TRAP_EN, B_JUMP_EX with target_EX=32'h102: next pc=TRAP_VEC=32'h100; misalign_trap pulses for one cycle; bad_target=32'h102. Without the macro: next pc=32'h100 via alignment masking, and no trap.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch PC controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ID   = 2'd1,
        SRC_EX   = 2'd2
    } redirect_src_e;

    localparam logic [31:0] ILEN             = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/fetch_pc_ctrl_redirect_arb.sv
// Combinational redirect arbiter: picks the oldest redirect (EX over ID)
// and produces the wrong-path flush pair. The target is passed through raw;
// alignment is handled where the PC is loaded.
module redirect_arb
    import fetch_pkg::*;
(
    input  logic          jal_ID,
    input  logic          jalr_ID,
    input  logic [31:0]   target_ID,
    input  logic          B_JUMP_EX,
    input  logic [31:0]   target_EX,
    output redirect_src_e src,
    output logic [31:0]   tgt,
    output logic          flush_IF_ID,
    output logic          flush_ID_EX
);

    // EX is older than ID, so a taken branch makes any ID jump wrong-path
    always_comb begin
        src         = SRC_NONE;
        tgt         = target_ID;
        flush_IF_ID = 1'b0;
        flush_ID_EX = 1'b0;
        if (B_JUMP_EX) begin
            src         = SRC_EX;
            tgt         = target_EX;
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (jal_ID || jalr_ID) begin
            src         = SRC_ID;
            tgt         = target_ID;
            flush_IF_ID = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// IF-stage program counter with redirect arbitration and a one-entry
// pending-redirect buffer for redirects that arrive while fetch is held.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
`endif
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_IF,
    input  logic        jal_ID,
    input  logic        jalr_ID,
    input  logic [31:0] target_ID,
    input  logic        B_JUMP_EX,
    input  logic [31:0] target_EX,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] pc_out_IF,
    output logic [31:0] pc_plus4_IF,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
`ifdef PC_MISALIGN_TRAP_EN
    output logic        misalign_trap,
    output logic [31:0] bad_target,
`endif
    output logic        redirect_pending
);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pend_q, pend_d;
    redirect_src_e pend_src_q, pend_src_d;

    redirect_src_e req_src;
    logic [31:0]   req_tgt;
    logic          hold;
    logic          load_en;
    logic [31:0]   load_tgt;

`ifdef PC_MISALIGN_TRAP_EN
    logic          trap_q, trap_d;
    logic [31:0]   bad_q, bad_d;
`endif

    redirect_arb u_arb (
        .jal_ID      (jal_ID),
        .jalr_ID     (jalr_ID),
        .target_ID   (target_ID),
        .B_JUMP_EX   (B_JUMP_EX),
        .target_EX   (target_EX),
        .src         (req_src),
        .tgt         (req_tgt),
        .flush_IF_ID (flush_IF_ID),
        .flush_ID_EX (flush_ID_EX)
    );

    assign fetch_valid      = (state_q != BOOT);
    assign hold             = stall_IF | (fetch_valid & ~fetch_ready);
    assign pc_out_IF        = pc_q;
    assign pc_plus4_IF      = pc_q + ILEN;
    assign redirect_pending = (state_q == PEND);

    // Next-state, PC and pending-buffer selection; redirect targets are
    // funnelled through load_en/load_tgt so alignment is applied in one place
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_src_d = pend_src_q;
        load_en    = 1'b0;
        load_tgt   = pc_q;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d     = 1'b0;
        bad_d      = bad_q;
`endif
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (req_src != SRC_NONE) begin
                    if (!hold) begin
                        load_en  = 1'b1;
                        load_tgt = req_tgt;
                    end else begin
                        pend_d     = req_tgt;
                        pend_src_d = req_src;
                        state_d    = PEND;
                    end
                end else if (!hold) begin
                    pc_d = pc_q + ILEN;
                end
            end
            PEND: begin
                // An EX entry is never displaced by a younger ID jump
                if ((req_src == SRC_EX) ||
                    ((req_src == SRC_ID) && (pend_src_q == SRC_ID))) begin
                    pend_d     = req_tgt;
                    pend_src_d = req_src;
                end
                if (!hold) begin
                    load_en  = 1'b1;
                    load_tgt = pend_d;
                    state_d  = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (load_en) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (load_tgt[1]) begin
                pc_d   = TRAP_VEC;
                trap_d = 1'b1;
                bad_d  = load_tgt;
            end else begin
                pc_d = load_tgt & ~32'h1;
            end
`else
            pc_d = load_tgt & ~32'h3;
`endif
        end
    end

    // State, PC and pending-buffer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= 32'h0;
            pend_src_q <= SRC_NONE;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_src_q <= pend_src_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    // Trap pulse and captured offending target
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
            bad_q  <= 32'h0;
        end else begin
            trap_q <= trap_d;
            bad_q  <= bad_d;
        end
    end

    assign misalign_trap = trap_q;
    assign bad_target    = bad_q;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed testbench for fetch_pc_ctrl: a vector table for the main stream
// plus hand-written sequences for pending-buffer and reset corner cases.
module tb_fetch_pc_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_IF;
    logic        jal_ID;
    logic        jalr_ID;
    logic [31:0] target_ID;
    logic        B_JUMP_EX;
    logic [31:0] target_EX;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc_out_IF;
    logic [31:0] pc_plus4_IF;
    logic        flush_IF_ID;
    logic        flush_ID_EX;
    logic        redirect_pending;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_trap;
    logic [31:0] bad_target;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        stall;
        logic        jal;
        logic        jalr;
        logic [31:0] tid;
        logic        bj;
        logic [31:0] tex;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_fi;
        logic        exp_fe;
        logic        exp_pend;
        logic        exp_trap;
        logic [31:0] exp_bad;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vec [NVEC];

    fetch_pc_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .stall_IF         (stall_IF),
        .jal_ID           (jal_ID),
        .jalr_ID          (jalr_ID),
        .target_ID        (target_ID),
        .B_JUMP_EX        (B_JUMP_EX),
        .target_EX        (target_EX),
        .fetch_ready      (fetch_ready),
        .fetch_valid      (fetch_valid),
        .pc_out_IF        (pc_out_IF),
        .pc_plus4_IF      (pc_plus4_IF),
        .flush_IF_ID      (flush_IF_ID),
        .flush_ID_EX      (flush_ID_EX),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign_trap    (misalign_trap),
        .bad_target       (bad_target),
`endif
        .redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic stall, input logic jal, input logic jalr,
                                  input logic [31:0] tid, input logic bj,
                                  input logic [31:0] tex, input logic ready);
        stall_IF    = stall;
        jal_ID      = jal;
        jalr_ID     = jalr;
        target_ID   = tid;
        B_JUMP_EX   = bj;
        target_EX   = tex;
        fetch_ready = ready;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stall jal jalr tid bj tex ready | valid pc fi fe pend trap bad
        vec[0]  = '{0,0,0,32'h0,  0,32'h0,        1, 0,32'h0,        0,0,0,0,32'h0};
        vec[1]  = '{0,0,0,32'h0,  0,32'h0,        1, 1,32'h0,        0,0,0,0,32'h0};
        vec[2]  = '{0,0,0,32'h0,  0,32'h0,        1, 1,32'h4,        0,0,0,0,32'h0};
        vec[3]  = '{0,0,0,32'h0,  0,32'h0,        1, 1,32'h8,        0,0,0,0,32'h0};
        vec[4]  = '{0,0,0,32'h0,  0,32'h0,        1, 1,32'hC,        0,0,0,0,32'h0};
        vec[5]  = '{0,0,0,32'h0,  0,32'h0,        0, 1,32'h10,       0,0,0,0,32'h0};
        vec[6]  = '{0,0,0,32'h0,  0,32'h0,        0, 1,32'h10,       0,0,0,0,32'h0};
        vec[7]  = '{0,0,0,32'h0,  0,32'h0,        1, 1,32'h10,       0,0,0,0,32'h0};
        vec[8]  = '{0,1,0,32'h40, 1,32'h80,       1, 1,32'h14,       1,1,0,0,32'h0};
        vec[9]  = '{1,0,1,32'h201,0,32'h0,        1, 1,32'h80,       1,0,0,0,32'h0};
        vec[10] = '{1,0,0,32'h0,  1,32'h300,      1, 1,32'h80,       1,1,1,0,32'h0};
        vec[11] = '{1,0,0,32'h0,  0,32'h0,        1, 1,32'h80,       0,0,1,0,32'h0};
        vec[12] = '{0,0,0,32'h0,  0,32'h0,        1, 1,32'h80,       0,0,1,0,32'h0};
        vec[13] = '{0,0,0,32'h0,  0,32'h0,        1, 1,32'h300,      0,0,0,0,32'h0};
        vec[14] = '{0,1,0,32'h41, 0,32'h0,        1, 1,32'h304,      1,0,0,0,32'h0};
        vec[15] = '{0,0,0,32'h0,  1,32'h102,      1, 1,32'h40,       1,1,0,0,32'h0};
        vec[16] = '{0,0,0,32'h0,  1,32'hFFFF_FFF8,1, 1,32'h100,      1,1,0,1,32'h102};
        vec[17] = '{0,0,0,32'h0,  0,32'h0,        1, 1,32'hFFFF_FFF8,0,0,0,0,32'h102};
        vec[18] = '{0,0,0,32'h0,  0,32'h0,        1, 1,32'hFFFF_FFFC,0,0,0,0,32'h102};
        vec[19] = '{0,0,0,32'h0,  0,32'h0,        1, 1,32'h0,        0,0,0,0,32'h102};

        rst = 1'b1;
        apply_stimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
        step();
        check_output("reset_valid", {31'b0, fetch_valid}, 32'h0);
        check_output("reset_pc", pc_out_IF, 32'h0);
        check_output("reset_pend", {31'b0, redirect_pending}, 32'h0);
        check_output("reset_flush", {30'b0, flush_IF_ID, flush_ID_EX}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vec[i].stall, vec[i].jal, vec[i].jalr, vec[i].tid,
                           vec[i].bj, vec[i].tex, vec[i].ready);
            @(negedge clk);
            check_output($sformatf("v%0d_valid", i), {31'b0, fetch_valid}, {31'b0, vec[i].exp_valid});
            check_output($sformatf("v%0d_pc", i), pc_out_IF, vec[i].exp_pc);
            check_output($sformatf("v%0d_pc4", i), pc_plus4_IF, vec[i].exp_pc + 32'd4);
            check_output($sformatf("v%0d_fIFID", i), {31'b0, flush_IF_ID}, {31'b0, vec[i].exp_fi});
            check_output($sformatf("v%0d_fIDEX", i), {31'b0, flush_ID_EX}, {31'b0, vec[i].exp_fe});
            check_output($sformatf("v%0d_pend", i), {31'b0, redirect_pending}, {31'b0, vec[i].exp_pend});
`ifdef PC_MISALIGN_TRAP_EN
            check_output($sformatf("v%0d_trap", i), {31'b0, misalign_trap}, {31'b0, vec[i].exp_trap});
            check_output($sformatf("v%0d_bad", i), bad_target, vec[i].exp_bad);
`endif
            @(posedge clk);
            #1;
        end

        // Pending EX entry survives a later ID jump
        apply_stimulus(1, 0, 0, 32'h0, 1, 32'h600, 1);
        step();
        check_output("exkeep_pend", {31'b0, redirect_pending}, 32'h1);
        apply_stimulus(1, 1, 0, 32'h700, 0, 32'h0, 1);
        step();
        apply_stimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
        step();
        check_output("exkeep_pc", pc_out_IF, 32'h600);
        check_output("exkeep_pend_clr", {31'b0, redirect_pending}, 32'h0);

        // New EX request on release beats a pending ID entry
        apply_stimulus(1, 1, 0, 32'h800, 0, 32'h0, 1);
        step();
        check_output("relwin_pend", {31'b0, redirect_pending}, 32'h1);
        apply_stimulus(0, 0, 0, 32'h0, 1, 32'h900, 1);
        #1;
        check_output("relwin_flush", {30'b0, flush_IF_ID, flush_ID_EX}, 32'h3);
        step();
        check_output("relwin_pc", pc_out_IF, 32'h900);

        // Reset while a redirect is pending, then redirect ignored in BOOT
        apply_stimulus(1, 0, 0, 32'h0, 1, 32'hA00, 1);
        step();
        check_output("rstpend_pend", {31'b0, redirect_pending}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("rstpend_pc", pc_out_IF, 32'h0);
        check_output("rstpend_valid", {31'b0, fetch_valid}, 32'h0);
        check_output("rstpend_pend_clr", {31'b0, redirect_pending}, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
        check_output("rstpend_trap", {31'b0, misalign_trap}, 32'h0);
        check_output("rstpend_bad", bad_target, 32'h0);
`endif
        apply_stimulus(0, 0, 0, 32'h0, 1, 32'hB00, 1);
        step();
        check_output("boot_ignore_pc", pc_out_IF, 32'h0);
        check_output("boot_valid", {31'b0, fetch_valid}, 32'h1);
        apply_stimulus(0, 0, 0, 32'h0, 0, 32'h0, 1);
        step();
        check_output("boot_next_pc", pc_out_IF, 32'h4);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
